// File: rtl/alu32_pkg.sv
// Shared constants and state encoding for the ALU32 serial datapath blocks.
package alu32_pkg;

    localparam int WIDTH = 32;
    localparam int NIB   = WIDTH / 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/g_sub4.sv
// Combinational 4-bit ripple subtractor built from per-bit full-subtractor gates.
module g_sub4 (
    input  logic [3:0] In1,
    input  logic [3:0] In2,
    input  logic       BI,
    output logic [3:0] Out,
    output logic       BO
);

    logic [4:0] bchain;
    logic [3:0] axb;

    assign bchain[0] = BI;

    // Borrow out of each bit when the minuend bit is 0 and the subtrahend is 1,
    // or when the bits are equal and a borrow arrives from below.
    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign axb[i]      = In1[i] ^ In2[i];
        assign Out[i]      = axb[i] ^ bchain[i];
        assign bchain[i+1] = (~In1[i] & In2[i]) | (~axb[i] & bchain[i]);
    end

    assign BO = bchain[4];

endmodule

// File: rtl/g_serial_sub32.sv
// Nibble-serial subtractor: Out = In1 - In2 - BI, one 4-bit step per clock.
module g_serial_sub32 #(
    parameter int WIDTH = alu32_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             BI,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Out,
    output logic             BO,
    output logic             V,
    output logic             Z
);

    import alu32_pkg::*;

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] opa, opb, res, res_nx;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic [3:0]       a_nib, b_nib, d_nib;
    logic             nib_bo;
    logic             accept, last;

    assign a_nib  = opa[{cnt, 2'b00} +: 4];
    assign b_nib  = opb[{cnt, 2'b00} +: 4];
    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(NIB - 1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    g_sub4 u_sub4 (
        .In1 (a_nib),
        .In2 (b_nib),
        .BI  (borrow),
        .Out (d_nib),
        .BO  (nib_bo)
    );

    // The full result as it stands after this edge's nibble is inserted.
    always_comb begin
        res_nx = res;
        res_nx[{cnt, 2'b00} +: 4] = d_nib;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = accept ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            Out    <= '0;
            BO     <= 1'b0;
            V      <= 1'b0;
            Z      <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                opa    <= In1;
                opb    <= In2;
                borrow <= BI;
                cnt    <= '0;
                res    <= '0;
            end else if (state == RUN) begin
                res    <= res_nx;
                borrow <= nib_bo;
                cnt    <= cnt + 1'b1;
                // Visible flags change only when the last nibble lands.
                if (last) begin
                    Out <= res_nx;
                    BO  <= nib_bo;
                    V   <= (opa[WIDTH-1] != opb[WIDTH-1]) && (res_nx[WIDTH-1] != opa[WIDTH-1]);
                    Z   <= (res_nx == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_g_serial_sub32.sv
// Self-checking bench for g_serial_sub32 against a plain-arithmetic reference.
module tb_g_serial_sub32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] In1, In2;
    logic        BI;
    logic        busy, done;
    logic [31:0] Out;
    logic        BO, V, Z;

    int compared = 0;
    int mismatched = 0;

    g_serial_sub32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .In1   (In1),
        .In2   (In2),
        .BI    (BI),
        .busy  (busy),
        .done  (done),
        .Out   (Out),
        .BO    (BO),
        .V     (V),
        .Z     (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=expired expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: difference as integers, flags from range checks.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic bi,
                         output logic [31:0] o, output logic bo, output logic v, output logic z);
        longint sd;
        longint unsigned ua, ub;
        ua = a;
        ub = b;
        sd = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
        o  = 32'(ua - ub - bi);
        bo = (ua < ub + bi);
        v  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        z  = (o == 32'd0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkResult(input string tag, input logic [31:0] a, input logic [31:0] b, input logic bi);
        logic [31:0] eo;
        logic ebo, ev, ez;
        model(a, b, bi, eo, ebo, ev, ez);
        checkOutput({tag, ".Out"}, Out, eo);
        checkOutput({tag, ".BO"}, {31'd0, BO}, {31'd0, ebo});
        checkOutput({tag, ".V"}, {31'd0, V}, {31'd0, ev});
        checkOutput({tag, ".Z"}, {31'd0, Z}, {31'd0, ez});
    endtask

    // Presents an operation so that the next rising edge accepts it, then drops start.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic bi);
        @(negedge clk);
        In1 = a;
        In2 = b;
        BI = bi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Steps negedges until done, counting from the negedge after the accepting edge (1).
    task automatic waitDone(input int cyc0, output int cyc, output int busyCnt);
        cyc = cyc0;
        busyCnt = 0;
        while (!done && cyc < 20) begin
            if (busy) busyCnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b, input logic bi);
        int cyc, bc;
        applyStimulus(a, b, bi);
        waitDone(1, cyc, bc);
        checkOutput({tag, ".latency"}, cyc, 32'd9);
        checkOutput({tag, ".busycycles"}, bc, 32'd8);
        checkResult(tag, a, b, bi);
        @(negedge clk);
        checkOutput({tag, ".donepulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc, bc;
        logic [31:0] ra, rb;
        logic rbi;

        rst_n = 1'b0;
        start = 1'b0;
        In1 = '0;
        In2 = '0;
        BI = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset.busy", {31'd0, busy}, 32'd0);
        checkOutput("reset.done", {31'd0, done}, 32'd0);
        checkOutput("reset.Out", Out, 32'd0);
        checkOutput("reset.flags", {29'd0, BO, V, Z}, 32'd0);
        rst_n = 1'b1;

        runOp("t1", 32'h00000005, 32'h00000003, 1'b0);
        runOp("t2a", 32'h00000000, 32'h00000001, 1'b0);
        runOp("t2b", 32'h80000000, 32'h00000001, 1'b0);
        runOp("t3a", 32'h12345678, 32'h12345678, 1'b0);
        runOp("t3b", 32'h12345678, 32'h12345678, 1'b1);

        // Operands and start toggled mid-run must not disturb the latched operation.
        applyStimulus(32'hA5A50F0F, 32'h0F0FA5A5, 1'b1);
        @(negedge clk);
        @(negedge clk);
        In1 = 32'hFFFFFFFF;
        In2 = 32'h00000000;
        BI = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(4, cyc, bc);
        checkOutput("t4.latency", cyc, 32'd9);
        checkResult("t4", 32'hA5A50F0F, 32'h0F0FA5A5, 1'b1);
        @(negedge clk);
        checkOutput("t4.donepulse", {31'd0, done}, 32'd0);
        checkOutput("t4.idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a run.
        applyStimulus(32'h00000001, 32'h00000002, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5.busy", {31'd0, busy}, 32'd0);
        checkOutput("t5.done", {31'd0, done}, 32'd0);
        checkOutput("t5.Out", Out, 32'd0);
        checkOutput("t5.flags", {29'd0, BO, V, Z}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("t5post", 32'hDEADBEEF, 32'h01234567, 1'b1);

        // Back-to-back random operations with start held high throughout.
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : 32'($urandom);
            rbi = 1'($urandom_range(0, 1));
            In1 = ra;
            In2 = rb;
            BI = rbi;
            start = 1'b1;
            @(negedge clk);
            In1 = $urandom;
            In2 = $urandom;
            BI = 1'($urandom_range(0, 1));
            waitDone(1, cyc, bc);
            checkOutput("t6.gap", cyc, 32'd9);
            checkResult("t6", ra, rb, rbi);
        end
        start = 1'b0;
        @(negedge clk);
        checkOutput("t6.end", {30'd0, busy, done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
